// File: rtl/vc_intc_pkg.sv
// Shared register map and CTRL bit positions for the vc interrupt controller.
package vc_intc_pkg;

  localparam logic [3:0] REG_PEND  = 4'd0;
  localparam logic [3:0] REG_EN    = 4'd1;
  localparam logic [3:0] REG_MODE  = 4'd2;
  localparam logic [3:0] REG_POL   = 4'd3;
  localparam logic [3:0] REG_CLAIM = 4'd4;
  localparam logic [3:0] REG_CTRL  = 4'd5;
  localparam logic [3:0] REG_SET   = 4'd6;

  localparam int CTRL_GIE = 0;
  localparam int CTRL_IRQ = 1;

endpackage

// File: rtl/vc_intc_if.sv
// I/O register bus between the execute unit and the interrupt controller.
interface vc_intc_if #(
  parameter int RV = 16
) ();
  logic [3:0]    io_addr;
  logic          io_write;
  logic          io_read;
  logic [RV-1:0] io_wdata;
  logic [RV-1:0] io_rdata;

  modport master (output io_addr, output io_write, output io_read, output io_wdata,
                  input io_rdata);
  modport slave  (input io_addr, input io_write, input io_read, input io_wdata,
                  output io_rdata);
endinterface

// File: rtl/vc_intc_src.sv
// One interrupt source: optional synchroniser, polarity, edge history and
// the sticky edge-mode pending flop.
module vc_intc_src #(
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic src_in,
  input  logic pol,
  input  logic mode,
  input  logic cfg_upd,
  input  logic set_req,
  input  logic clr_req,
  output logic pend
);

  logic s_raw;
  logic s;
  logic hist;
  logic rise;
  logic pend_e;

  generate
    if (SYNC) begin : g_sync
      logic sync1;
      logic sync2;
      // Two-flop synchroniser for the asynchronous source.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
        end else begin
          sync1 <= src_in;
          sync2 <= sync1;
        end
      end
      assign s_raw = sync2;
    end else begin : g_nosync
      assign s_raw = src_in;
    end
  endgenerate

  assign s = s_raw ^ pol;
  // The cycle after a MODE/POL change compares against stale history, so it
  // must not count as an edge.
  assign rise = s & ~hist & ~cfg_upd;

  // Edge history always tracks the polarity-corrected level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist <= 1'b0;
    else        hist <= s;
  end

  // Edge pending: set beats clear; level mode discards it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                pend_e <= 1'b0;
    else if (!mode)            pend_e <= 1'b0;
    else if (rise || set_req)  pend_e <= 1'b1;
    else if (clr_req)          pend_e <= 1'b0;
  end

  assign pend = mode ? pend_e : s;

endmodule

// File: rtl/vc_intc.sv
// Parametrised interrupt controller: per-source config registers, claim
// priority encoder, register read mux and the registered interrupt request.
module vc_intc
  import vc_intc_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int RV   = 16,
  parameter bit SYNC = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  vc_intc_if.slave        bus,
  output logic            interrupt
);

  logic [NSRC-1:0] en;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] pol;
  logic [NSRC-1:0] cfg_upd;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] claim_oh;
  logic [RV-1:0]   claim_val;
  logic            gie;
  logic            wr_pend, wr_en, wr_mode, wr_pol, wr_ctrl, wr_set, rd_claim;
  logic            unused_wdata;

  assign wr_pend  = bus.io_write && (bus.io_addr == REG_PEND);
  assign wr_en    = bus.io_write && (bus.io_addr == REG_EN);
  assign wr_mode  = bus.io_write && (bus.io_addr == REG_MODE);
  assign wr_pol   = bus.io_write && (bus.io_addr == REG_POL);
  assign wr_ctrl  = bus.io_write && (bus.io_addr == REG_CTRL);
  assign wr_set   = bus.io_write && (bus.io_addr == REG_SET);
  assign rd_claim = bus.io_read  && (bus.io_addr == REG_CLAIM);

  assign unused_wdata = ^bus.io_wdata;
  assign active = pend & en;

  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_src
      vc_intc_src #(.SYNC(SYNC)) u_src (
        .clk     (clk),
        .reset   (reset),
        .src_in  (src[i]),
        .pol     (pol[i]),
        .mode    (mode[i]),
        .cfg_upd (cfg_upd[i]),
        .set_req (wr_set & bus.io_wdata[i]),
        .clr_req ((wr_pend & bus.io_wdata[i]) | (rd_claim & claim_oh[i])),
        .pend    (pend[i])
      );
    end
  endgenerate

  // Lowest-index enabled pending source wins the claim.
  always_comb begin
    claim_oh  = '0;
    claim_val = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_oh    = '0;
        claim_oh[i] = 1'b1;
        claim_val   = RV'(i + 1);
      end
    end
  end

  // Configuration registers; cfg_upd flags sources whose MODE/POL bit flips.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en      <= '0;
      mode    <= '0;
      pol     <= '0;
      gie     <= 1'b0;
      cfg_upd <= '0;
    end else begin
      cfg_upd <= (wr_mode ? (bus.io_wdata[NSRC-1:0] ^ mode) : '0)
               | (wr_pol  ? (bus.io_wdata[NSRC-1:0] ^ pol)  : '0);
      if (wr_en)   en   <= bus.io_wdata[NSRC-1:0];
      if (wr_mode) mode <= bus.io_wdata[NSRC-1:0];
      if (wr_pol)  pol  <= bus.io_wdata[NSRC-1:0];
      if (wr_ctrl) gie  <= bus.io_wdata[CTRL_GIE];
    end
  end

  // Registered request to the execute unit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) interrupt <= 1'b0;
    else        interrupt <= gie && (|active);
  end

  // Combinational register read mux.
  always_comb begin
    bus.io_rdata = '0;
    case (bus.io_addr)
      REG_PEND:  bus.io_rdata = RV'(pend);
      REG_EN:    bus.io_rdata = RV'(en);
      REG_MODE:  bus.io_rdata = RV'(mode);
      REG_POL:   bus.io_rdata = RV'(pol);
      REG_CLAIM: bus.io_rdata = claim_val;
      REG_CTRL: begin
        bus.io_rdata[CTRL_GIE] = gie;
        bus.io_rdata[CTRL_IRQ] = interrupt;
      end
      default:   bus.io_rdata = '0;
    endcase
  end

endmodule

// File: doc/vc_intc.md
# vc_intc

Parametrised interrupt controller for the vc SoC, successor to the fixed three-source controller. Collects NSRC asynchronous interrupt sources (uart, spi, gpio and future peripherals), synchronises them, supports per-source edge/level mode, polarity, enable and software-set, and presents a single registered `interrupt` to the execute unit. A claim register returns the highest-priority pending source and acknowledges it in the same read. Registers sit in the I/O space at `addr[8:5]==2`.

## Interface
- NSRC, 8: number of sources, 1..RV
- RV, 16: register/data width
- SYNC, 1: 1 = two-flop synchroniser per source, 0 = sources already synchronous
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- src  in  NSRC  raw interrupt sources, bit 0 = highest priority
- io_addr  in  4  register index (`addr[4:1]`)
- io_write  in  1  register write strobe, one cycle
- io_read  in  1  register read strobe, one cycle
- io_wdata  in  RV  write data
- io_rdata  out  RV  read data, combinational from io_addr
- interrupt  out  1  registered request to execute unit

## Operation
- Registers (bits above NSRC-1 read 0, writes ignored):
  - 0 PEND: read pending; write 1 clears edge-mode bits; level bits unaffected
  - 1 EN: per-source enable, reset 0
  - 2 MODE: 1 = edge, 0 = level, reset 0
  - 3 POL: 1 = active-low / falling edge, reset 0
  - 4 CLAIM: read returns id+1 of lowest-index bit of PEND&EN, 0 if none; the read clears that bit if edge-mode; write ignored
  - 5 CTRL: bit0 global enable (reset 0); bit1 read-only = current `interrupt`
  - 6 SET: write 1 sets pending of edge-mode sources; reads 0
  - 7..15: read 0, writes ignored
- Per source: s = synchronised src ^ POL. Level: PEND bit = s (combinational from s register). Edge: PEND bit set on s rising (0 -> 1 between consecutive cycles), held until cleared.
- MODE or POL change: edge detector history is updated to the new s without generating an edge; existing edge pending bits keep their value; switching to level discards the edge pending bit.
- interrupt <= CTRL.gie && |(PEND & EN).
- io_read with io_addr != 4 has no side effects.

## Timing
- Reset: PEND, EN, MODE, POL, CTRL, edge history, synchroniser flops = 0; interrupt = 0; io_rdata follows addr (0 for CLAIM).
- Latency SYNC=1: src edge at cycle 0 -> PEND visible cycle 3 -> interrupt high cycle 4. SYNC=0: PEND cycle 1, interrupt cycle 2.
- Register write effective next cycle; interrupt reflects it one cycle later.
- Simultaneous set and clear of same edge bit (new edge vs PEND W1C, CLAIM read, or SET vs W1C): set wins, bit stays 1.
- CLAIM read while higher-priority source becomes pending same cycle: returned id and cleared bit are those from the pre-cycle state; the new source is not lost.
- Source pulse shorter than one clk with SYNC=1: not guaranteed captured. Pulses ≥2 clk always captured once.
- Reset asserted mid-operation clears all state asynchronously; interrupt drops without waiting for clk.

## Structure
- Package `vc_intc_pkg`: register index constants (PEND..SET), CTRL bit positions.
- Sub-module `vc_intc_src`: one source — synchroniser (SYNC), polarity, edge history, pending flop with set/clear priority; instantiated NSRC times via generate.
- Top holds EN/MODE/POL/CTRL, priority encoder, read mux, interrupt flop.

## Test plan
- Reset, all registers read 0; EN=0x01, CTRL=1, src[0] rising -> PEND=0x01 at cycle 3, interrupt at cycle 4; CLAIM reads 1, PEND=0, interrupt low 2 cycles later.
- MODE=0 (level), POL=0x04, src[2]=0, EN=0x04, CTRL=1 -> interrupt high; W1C PEND=0x04 no effect; src[2]=1 -> interrupt drops.
- Edges on src[5] and src[1] same cycle, all enabled edge -> CLAIM returns 2, then 6, then 0.
- New src[3] edge same cycle as PEND W1C 0x08 -> PEND bit 3 remains 1.
- SET=0x80 with MODE=0xFF, EN=0x80, CTRL=0 -> PEND=0x80, interrupt 0; CTRL=1 -> interrupt 1.
- Assert reset with interrupt high, between clk edges -> interrupt 0 immediately; all registers 0 after release.
